// File: rtl/line_raster_unit.sv
// Bresenham line rasterizer: latches endpoints from the primitive FIFO head and
// emits one pixel per enable rising edge, handshaking data_ready / line_done.
//
// state | meaning
// IDLE  | waiting for enable; endpoints and step terms latched on entry to LOAD
// LOAD  | settle cycle after precompute
// EMIT  | pix_x/pix_y valid, data_ready high for this cycle only
// HOLD  | waiting for the next enable rising edge to step or finish
// DONE  | every pixel emitted, line_done held until clear
module line_raster_unit #(
    parameter int COORD_W = 10
) (
    input  logic               clk,
    input  logic               nreset,
    input  logic               enable,
    input  logic               clear,
    input  logic [COORD_W-1:0] x0,
    input  logic [COORD_W-1:0] y0,
    input  logic [COORD_W-1:0] x1,
    input  logic [COORD_W-1:0] y1,
    output logic [COORD_W-1:0] pix_x,
    output logic [COORD_W-1:0] pix_y,
    output logic               data_ready,
    output logic               line_done
);

    localparam int DW  = COORD_W + 1;
    localparam int EW  = COORD_W + 2;
    localparam int E2W = COORD_W + 3;

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_EMIT, S_HOLD, S_DONE} state_t;

    state_t state_q, state_d;
    logic   enable_q;
    logic   en_rise, at_end, load, step;

    logic [COORD_W-1:0] cur_x_q, cur_x_d, cur_y_q, cur_y_d;
    logic [COORD_W-1:0] end_x_q, end_x_d, end_y_q, end_y_d;
    logic [COORD_W-1:0] pix_x_q, pix_x_d, pix_y_q, pix_y_d;
    logic [COORD_W-1:0] adx, ady;
    logic signed [DW-1:0]  dx_q, dx_d, dy_q, dy_d;
    logic signed [1:0]     sx_q, sx_d, sy_q, sy_d;
    logic signed [EW-1:0]  err_q, err_d, dx_ew, dy_ew, dx_add, dy_add;
    logic signed [E2W-1:0] e2, dx_e2, dy_e2;
    logic                  step_x, step_y;

    assign en_rise = enable & ~enable_q;
    assign at_end  = (cur_x_q == end_x_q) && (cur_y_q == end_y_q);
    assign load    = (state_q == S_IDLE) && enable && !clear;
    assign step    = (state_q == S_HOLD) && en_rise && !clear && !at_end;

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (clear) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: if (enable) state_d = S_LOAD;
                S_LOAD: state_d = S_EMIT;
                S_EMIT: state_d = S_HOLD;
                S_HOLD: if (en_rise) state_d = at_end ? S_DONE : S_EMIT;
                S_DONE: state_d = S_DONE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_comb begin
        data_ready = (state_q == S_EMIT);
        line_done  = (state_q == S_DONE);
    end

    // Step decisions use the error term from before this step's updates.
    always_comb begin
        cur_x_d = cur_x_q;
        cur_y_d = cur_y_q;
        end_x_d = end_x_q;
        end_y_d = end_y_q;
        dx_d    = dx_q;
        dy_d    = dy_q;
        sx_d    = sx_q;
        sy_d    = sy_q;
        err_d   = err_q;
        pix_x_d = pix_x_q;
        pix_y_d = pix_y_q;

        adx    = (x1 >= x0) ? (x1 - x0) : (x0 - x1);
        ady    = (y1 >= y0) ? (y1 - y0) : (y0 - y1);
        e2     = $signed({err_q, 1'b0});
        dx_ew  = $signed({dx_q[DW-1], dx_q});
        dy_ew  = $signed({dy_q[DW-1], dy_q});
        dx_e2  = $signed({{2{dx_q[DW-1]}}, dx_q});
        dy_e2  = $signed({{2{dy_q[DW-1]}}, dy_q});
        step_x = (e2 >= dy_e2);
        step_y = (e2 <= dx_e2);
        dy_add = step_x ? dy_ew : '0;
        dx_add = step_y ? dx_ew : '0;

        if (load) begin
            cur_x_d = x0;
            cur_y_d = y0;
            end_x_d = x1;
            end_y_d = y1;
            dx_d    = $signed({1'b0, adx});
            dy_d    = -$signed({1'b0, ady});
            sx_d    = (x0 < x1) ? 2'sb01 : 2'sb11;
            sy_d    = (y0 < y1) ? 2'sb01 : 2'sb11;
            err_d   = $signed({dx_d[DW-1], dx_d}) + $signed({dy_d[DW-1], dy_d});
        end else if (step) begin
            if (step_x) cur_x_d = cur_x_q + {{(COORD_W-2){sx_q[1]}}, sx_q};
            if (step_y) cur_y_d = cur_y_q + {{(COORD_W-2){sy_q[1]}}, sy_q};
            err_d = err_q + dy_add + dx_add;
        end

        if (state_d == S_EMIT) begin
            pix_x_d = cur_x_d;
            pix_y_d = cur_y_d;
        end
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            enable_q <= 1'b0;
            cur_x_q  <= '0;
            cur_y_q  <= '0;
            end_x_q  <= '0;
            end_y_q  <= '0;
            dx_q     <= '0;
            dy_q     <= '0;
            sx_q     <= '0;
            sy_q     <= '0;
            err_q    <= '0;
            pix_x_q  <= '0;
            pix_y_q  <= '0;
        end else begin
            enable_q <= enable;
            cur_x_q  <= cur_x_d;
            cur_y_q  <= cur_y_d;
            end_x_q  <= end_x_d;
            end_y_q  <= end_y_d;
            dx_q     <= dx_d;
            dy_q     <= dy_d;
            sx_q     <= sx_d;
            sy_q     <= sy_d;
            err_q    <= err_d;
            pix_x_q  <= pix_x_d;
            pix_y_q  <= pix_y_d;
        end
    end

    assign pix_x = pix_x_q;
    assign pix_y = pix_y_q;

endmodule

// File: tb/tb_line_raster_unit.sv
// Directed bench for line_raster_unit: hand-computed pixel sequences, latency,
// done/clear handshake, held-enable behaviour and asynchronous reset.
module tb_line_raster_unit;

    localparam int COORD_W = 10;

    logic               clk;
    logic               nreset;
    logic               enable;
    logic               clear;
    logic [COORD_W-1:0] x0, y0, x1, y1;
    logic [COORD_W-1:0] pix_x, pix_y;
    logic               data_ready;
    logic               line_done;

    int errors = 0;
    int checks = 0;

    line_raster_unit #(.COORD_W(COORD_W)) dut (
        .clk        (clk),
        .nreset     (nreset),
        .enable     (enable),
        .clear      (clear),
        .x0         (x0),
        .y0         (y0),
        .x1         (x1),
        .y1         (y1),
        .pix_x      (pix_x),
        .pix_y      (pix_y),
        .data_ready (data_ready),
        .line_done  (line_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic set_line(input int ax, input int ay, input int bx, input int by);
        x0 = ax[COORD_W-1:0];
        y0 = ay[COORD_W-1:0];
        x1 = bx[COORD_W-1:0];
        y1 = by[COORD_W-1:0];
    endtask

    // Raise enable, wait (bounded) for data_ready, check latency and pixel, drop enable.
    task automatic get_pixel(input int ex, input int ey, input int elat, input string tag);
        int lat;
        bit seen;
        lat = 0;
        seen = 1'b0;
        enable = 1'b1;
        for (int i = 0; i < 6 && !seen; i++) begin
            @(negedge clk);
            lat++;
            if (data_ready) seen = 1'b1;
        end
        chk({tag, " seen"}, int'(seen), 1);
        chk({tag, " latency"}, lat, elat);
        chk({tag, " x"}, int'(pix_x), ex);
        chk({tag, " y"}, int'(pix_y), ey);
        chk({tag, " done_low"}, int'(line_done), 0);
        enable = 1'b0;
        @(negedge clk);
        chk({tag, " pulse"}, int'(data_ready), 0);
    endtask

    // Final en_rise reaches DONE; enable stays high to confirm it is ignored; then clear.
    task automatic finish_line(input string tag);
        enable = 1'b1;
        @(negedge clk);
        chk({tag, " done"}, int'(line_done), 1);
        chk({tag, " no_dr"}, int'(data_ready), 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk({tag, " done_held"}, int'(line_done), 1);
            chk({tag, " dr_held"}, int'(data_ready), 0);
        end
        enable = 1'b0;
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        chk({tag, " cleared"}, int'(line_done), 0);
        @(negedge clk);
        chk({tag, " idle"}, int'(line_done), 0);
    endtask

    initial begin
        nreset = 1'b0;
        enable = 1'b0;
        clear  = 1'b0;
        set_line(0, 0, 0, 0);
        repeat (2) @(negedge clk);
        chk("rst pix_x", int'(pix_x), 0);
        chk("rst pix_y", int'(pix_y), 0);
        chk("rst dr", int'(data_ready), 0);
        chk("rst done", int'(line_done), 0);
        nreset = 1'b1;
        @(negedge clk);

        // Horizontal (0,0)->(3,0)
        set_line(0, 0, 3, 0);
        get_pixel(0, 0, 2, "h0");
        get_pixel(1, 0, 1, "h1");
        get_pixel(2, 0, 1, "h2");
        get_pixel(3, 0, 1, "h3");
        finish_line("h");
        chk("h pix retained x", int'(pix_x), 3);

        // Shallow (0,0)->(4,2)
        set_line(0, 0, 4, 2);
        get_pixel(0, 0, 2, "s0");
        get_pixel(1, 1, 1, "s1");
        get_pixel(2, 1, 1, "s2");
        get_pixel(3, 2, 1, "s3");
        get_pixel(4, 2, 1, "s4");
        finish_line("s");

        // Reverse diagonal (5,5)->(2,2); endpoints changed mid-line must be ignored
        set_line(5, 5, 2, 2);
        get_pixel(5, 5, 2, "r0");
        set_line(0, 0, 9, 9);
        get_pixel(4, 4, 1, "r1");
        get_pixel(3, 3, 1, "r2");
        get_pixel(2, 2, 1, "r3");
        finish_line("r");

        // Degenerate single point
        set_line(7, 9, 7, 9);
        get_pixel(7, 9, 2, "p0");
        finish_line("p");

        // Held enable: one pixel only until enable re-rises; clear after 2nd pixel
        set_line(0, 0, 3, 0);
        get_pixel(0, 0, 2, "c0");
        enable = 1'b1;
        @(negedge clk);
        chk("held first step", int'(data_ready), 1);
        chk("held first x", int'(pix_x), 1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("held no_dr", int'(data_ready), 0);
            chk("held x stable", int'(pix_x), 1);
        end
        enable = 1'b0;
        @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("abort no_done", int'(line_done), 0);
            chk("abort no_dr", int'(data_ready), 0);
        end
        chk("abort pix kept", int'(pix_x), 1);

        // Vertical (1,1)->(1,3) after abort
        set_line(1, 1, 1, 3);
        get_pixel(1, 1, 2, "v0");
        get_pixel(1, 2, 1, "v1");
        get_pixel(1, 3, 1, "v2");
        finish_line("v");

        // Asynchronous reset mid-line
        set_line(0, 0, 3, 0);
        get_pixel(0, 0, 2, "a0");
        get_pixel(1, 0, 1, "a1");
        #2;
        nreset = 1'b0;
        #1;
        chk("async pix_x", int'(pix_x), 0);
        chk("async pix_y", int'(pix_y), 0);
        chk("async dr", int'(data_ready), 0);
        chk("async done", int'(line_done), 0);
        @(negedge clk);
        nreset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("post rst no_dr", int'(data_ready), 0);
            chk("post rst no_done", int'(line_done), 0);
        end
        get_pixel(0, 0, 2, "a2");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/line_raster_unit.md
Name:
line_raster_unit

Overview:
- Bresenham line rasterizer for the 2D GPU core. It sits directly downstream of the core control unit.
- Takes the line endpoints at the head of the primitive FIFO and emits one pixel per enable request.
- Handshakes with the control FSM via enable → data_ready / line_done.
- The control unit's FIFO read pulse (clear) retires the line and rearms the block for the next primitive.

Parameters:
- COORD_W, 10, width of each unsigned pixel coordinate.

Ports:
- clk  in  1  system clock, rising edge.
- nreset  in  1  asynchronous active-low reset.
- enable  in  1  pixel request from control; high while the control unit is in a MAKE state.
- clear  in  1  one-cycle retire/abort pulse (control FIFO read).
- x0  in  COORD_W  start x; stable from first enable until clear.
- y0  in  COORD_W  start y.
- x1  in  COORD_W  end x.
- y1  in  COORD_W  end y.
- pix_x  out  COORD_W  current pixel x, registered.
- pix_y  out  COORD_W  current pixel y, registered.
- data_ready  out  1  one-cycle pulse; pix_x/pix_y are valid.
- line_done  out  1  level; all pixels of the line have been emitted.

Behaviour:
- Reset (nreset=0, async): state=IDLE; pix_x=0, pix_y=0; data_ready=0; line_done=0; enable_q=0; all arithmetic registers 0.
- enable_q is a registered copy of enable. Define en_rise = enable & ~enable_q.
- States: IDLE, LOAD, EMIT, HOLD, DONE.
- IDLE:
  - On enable=1: latch endpoints and precompute:
    - cur_x=x0, cur_y=y0
    - dx=|x1-x0|, dy=-|y1-y0|
    - sx=+1 if x0<x1 else -1; sy=+1 if y0<y1 else -1
    - err=dx+dy
  - Go to LOAD.
- LOAD: one settle cycle → EMIT. First data_ready therefore occurs 2 cycles after enable is first sampled high in IDLE.
- EMIT: pix_x/pix_y = cur; data_ready=1 for exactly this cycle → HOLD.
- HOLD:
  - data_ready=0; pix held stable.
  - Wait for en_rise. A continuously high enable never advances the line.
  - On en_rise with cur==(x1,y1) → DONE.
  - On en_rise otherwise, do one Bresenham step, then → EMIT:
    - e2=2*err
    - if e2>=dy: err+=dy, cur_x+=sx
    - if e2<=dx: err+=dx, cur_y+=sy
    - Both updates may apply in the same step.
- DONE: line_done=1 (level), data_ready=0; enable ignored; stays until clear.
- clear:
  - In any state: next cycle state=IDLE, line_done=0, data_ready=0. pix is retained.
  - clear has priority over enable/en_rise in the same cycle.
- Widths: err signed COORD_W+2 bits; e2 signed COORD_W+3 bits; dx, dy, sx, sy signed. No overflow is possible at these widths.
- Pixel count: max(dx, |dy|)+1. A degenerate line (x0==x1, y0==y1) emits exactly one pixel, then reaches DONE on the next en_rise.
- Endpoint inputs are only sampled in IDLE. Changes during a line have no effect.
- data_ready and line_done are never high in the same cycle.
- Reset mid-line: immediate return to IDLE with all outputs 0. No pixel or done is emitted afterwards without a new enable.

Test Plan:
- Horizontal line (0,0)→(3,0), enable pulsed per handshake → data_ready pulses with pixels (0,0),(1,0),(2,0),(3,0); 5th en_rise → line_done=1 held until clear, then line_done=0.
- Shallow line (0,0)→(4,2) → pixels exactly (0,0),(1,1),(2,1),(3,2),(4,2); then line_done.
- Reverse diagonal (5,5)→(2,2) → (5,5),(4,4),(3,3),(2,2) (sx=sy=-1); then line_done.
- Single point (7,9)→(7,9) → one data_ready with (7,9); next en_rise → line_done; enable held high in DONE causes no further pulses.
- enable held high continuously after first pixel → only one data_ready until enable falls and rises again.
- clear after 2nd pixel of (0,0)→(3,0) → IDLE next cycle, no line_done. Next enable with new endpoints (1,1)→(1,3) → (1,1),(1,2),(1,3).
- nreset asserted mid-line → outputs 0 immediately (async); no activity until next enable.
